// File: rtl/mix_phase_if.sv
// mix_phase_if: bundles the mix request, core-round handshake and result signals.
// Latency: none, wiring only.
// Backpressure: round_req/round_c are held by the master side of the core handshake until round_done.
interface mix_phase_if #(
  parameter int CWIDTH = 320,
  parameter int XWIDTH = 128
);
  logic              start;
  logic [127:0]      din;
  logic [1:0]        ds;
  logic [CWIDTH-1:0] cin;
  logic [XWIDTH-1:0] x;
  logic              round_req;
  logic [CWIDTH-1:0] round_c;
  logic [3:0]        round_idx;
  logic              round_done;
  logic [CWIDTH-1:0] round_cout;
  logic [CWIDTH-1:0] cout;
  logic              busy;
  logic              done;

  // Environment side: issues mixes and plays the core-round responder.
  modport master (
    output start, din, ds, cin, x, round_done, round_cout,
    input  round_req, round_c, round_idx, cout, busy, done
  );

  // Mixer side.
  modport slave (
    input  start, din, ds, cin, x, round_done, round_cout,
    output round_req, round_c, round_idx, cout, busy, done
  );
endinterface

// File: rtl/mix_phase.sv
// mix_phase: keyed XOR mixing of a 130-bit {ds,din} into a 320-bit capacity over 13 steps, each followed by a core round.
// Latency: done is captured 1+13*(2+W) edges after the start edge, W = extra WAIT cycles before round_done.
// Backpressure: round_req/round_c held stable until round_done; start is ignored while a mix is in flight.
module mix_phase #(
  parameter int CWIDTH = 320,  // five 64-bit words; only 320 is supported
  parameter int XWIDTH = 128   // four 32-bit key words; only 128 is supported
) (
  input  logic         clk,
  input  logic         reset,
  mix_phase_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, XOR, WAIT, DONE} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        step_q;
  logic [129:0]      m_q;
  logic [CWIDTH-1:0] cap_q;
  logic [CWIDTH-1:0] cap_xor;
  logic [XWIDTH-1:0] x_q;
  logic              res_vld_q;  // a completed result sits in cap_q
  logic [7:0]        base;
  logic [9:0]        seg;

  // State register; reset drops any mix in flight without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE, round_done only in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = XOR;
      XOR:     state_d = WAIT;
      WAIT:    if (bus.round_done) state_d = (step_q == 4'd12) ? DONE : XOR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-step key XOR: 10 message bits pick one key word for the low half of each capacity word.
  always_comb begin
    base    = {4'd0, step_q} * 8'd10;
    seg     = m_q[base +: 10];
    cap_xor = cap_q;
    for (int j = 0; j < 5; j++) begin
      cap_xor[64*j +: 32] = cap_q[64*j +: 32] ^ x_q[{seg[2*j +: 2], 5'd0} +: 32];
    end
  end

  // Datapath registers: input latch on start, key XOR, core-round result load, step count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q    <= 4'd0;
      cap_q     <= '0;
      m_q       <= '0;
      x_q       <= '0;
      res_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q       <= {bus.ds, bus.din};
            cap_q     <= bus.cin;
            x_q       <= bus.x;
            step_q    <= 4'd0;
            res_vld_q <= 1'b0;
          end
        end
        XOR: cap_q <= cap_xor;
        WAIT: begin
          if (bus.round_done) begin
            cap_q <= bus.round_cout;
            if (step_q != 4'd12) step_q <= step_q + 4'd1;
          end
        end
        DONE: res_vld_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.round_req = (state_q == WAIT);
  assign bus.round_c   = cap_q;
  assign bus.round_idx = step_q;
  assign bus.busy      = (state_q == XOR) || (state_q == WAIT);
  assign bus.done      = (state_q == DONE);
  // Result is exposed during the done pulse and afterwards in IDLE until the next start reloads cap_q.
  assign bus.cout      = ((state_q == DONE) || ((state_q == IDLE) && res_vld_q)) ? cap_q : '0;

endmodule

// File: doc/mix_phase.md
MIX_PHASE -- requirements
Module: mix_phase

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter CWIDTH SHALL default to 320 and be the capacity width, as five 64-bit words; only 320 is supported.
REQ-003 Parameter XWIDTH SHALL default to 128 and be the key-word width, as four 32-bit words; only 128 is supported.
REQ-004 The ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  begin mix; sampled only in IDLE
- din  in  128  message block
- ds  in  2  domain-separation bits
- cin  in  CWIDTH  initial capacity
- x  in  XWIDTH  key words x0..x3, where xi = x[32i+31:32i]
- round_req  out  1  core-round request
- round_c  out  CWIDTH  capacity presented to the core
- round_idx  out  4  current step number, 0..12
- round_done  in  1  core-round complete
- round_cout  in  CWIDTH  core-round result
- cout  out  CWIDTH  mixed capacity, to the downstream G stage
- busy  out  1  high in XOR and WAIT
- done  out  1  one-cycle completion pulse

Function
REQ-005 The mix input SHALL be the 130-bit value m = {ds, din}, consumed in 13 steps of 10 bits each, step s using m[10s+9:10s].
REQ-006 In step s, capacity word j (0..4, bits c[64j+63:64j]) SHALL XOR key word x[idx] into its low 32 bits, where idx = m[10s+2j+1:10s+2j]; the high 32 bits are unchanged.
REQ-007 The FSM SHALL have the states IDLE, XOR, WAIT and DONE.
REQ-008 In IDLE with start=1, the block SHALL latch din, ds, cin and x into internal registers, clear the step counter and go to XOR; start is ignored in every other state.
REQ-009 XOR SHALL last one cycle, apply REQ-006 to the capacity register for the current step, and go to WAIT.
REQ-010 In WAIT, round_req SHALL be 1 and round_c SHALL equal the capacity register and be held stable until round_done.
REQ-011 When round_done=1 is sampled in WAIT, the capacity register SHALL load round_cout; then:
- if step < 12: step increments and the FSM goes to XOR
- if step = 12: the FSM goes to DONE
REQ-012 round_done SHALL be ignored outside WAIT.
REQ-013 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-014 cout SHALL equal the capacity register while done=1 and while in IDLE after a completed mix; it holds until the next start.
REQ-015 round_idx SHALL equal the step counter.
REQ-016 Let W be the number of WAIT cycles before round_done is sampled, with W=0 meaning round_done is high in the first WAIT cycle. Each step then lasts 2+W cycles, and done SHALL assert 1+13*(2+W) cycles after the start-sampling edge; for W=0 that is 27 cycles.
REQ-017 round_c SHALL always reflect the capacity register.
REQ-018 round_req SHALL be 0 in every state other than WAIT.

Reset
REQ-019 While reset=1, the block SHALL be in IDLE, with the step counter, capacity register and latched inputs at 0.
REQ-020 While reset=1, round_req, busy and done SHALL be 0, round_idx 0, and cout and round_c all-zero.
REQ-021 Reset asserted at any point, including mid-WAIT, SHALL abort the mix immediately with no done pulse.
REQ-022 After reset deasserts, the next start SHALL run a complete, correct mix.

Verification
REQ-023 Reset test: assert reset with random inputs -> all outputs 0, FSM in IDLE.
REQ-024 Zero-message test: identity core stub with W=0; din=0, ds=0, cin=C, x=X -> done at cycle 27; cout = C with the low half of every word XORed with x0 (13 odd applications).
REQ-025 Domain-separation test: din=0, ds=2'b11, identity stub with W=0:
- words 0..3: low half XORed with x0
- word 4: low half XORed with x3 (the twelve x0 applications cancel)
REQ-026 Core-latency test: identity stub with W=5:
- round_req held 6 cycles per step
- round_c stable throughout each step
- round_idx steps 0..12
- done at cycle 92
REQ-027 Abort and robustness test:
- start pulses during busy -> ignored
- round_done pulses in IDLE -> ignored
- reset during step 6 -> round_req=0, cout=0, no done pulse
- following start with din=0, ds=0 -> matches the REQ-024 result
